lsu_gen2: RTL and testbench
===========================

LSU_GEN2 -- requirements
Module: lsu_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register and memory data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the WAITING-cycle limit used only when LSU_TIMEOUT_EN is defined.
REQ-004 The block SHALL have these ports: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  thread-active; low freezes all state and outputs.
REQ-007 core_state  in  3  core phase; 3'b011 = REQUEST, 3'b110 = UPDATE.
REQ-008 decoded_mem_read_enable, decoded_mem_write_enable  in  1 each  decoded LDR/STR.
REQ-009 rs, rt  in  DATA_WIDTH each  base register and store data.
REQ-010 decoded_offset  in  DATA_WIDTH  two's-complement address offset.
REQ-011 mem_read_ready, mem_write_ready  in  1 each  memory acknowledge.
REQ-012 mem_read_data  in  DATA_WIDTH  returned read data.
REQ-013 mem_read_valid, mem_write_valid  out  1 each  request strobes.
REQ-014 mem_read_address, mem_write_address  out  ADDR_WIDTH each; mem_write_data  out  DATA_WIDTH.
REQ-015 lsu_out  out  DATA_WIDTH  load result; lsu_state  out  2  FSM state; lsu_error  out  1  aborted-access flag.

Function
REQ-016 lsu_state SHALL encode IDLE=0, REQUESTING=1, WAITING=2, DONE=3; all outputs registered.
REQ-017 Effective address SHALL be (rs + decoded_offset) truncated or zero-extended to ADDR_WIDTH; wrap-around is silent.
REQ-018 IDLE -> REQUESTING SHALL occur when enable, core_state==REQUEST and either decode enable is high; otherwise IDLE holds.
REQ-019 If both decode enables are high, the read SHALL proceed and the write SHALL be dropped.
REQ-020 In REQUESTING the block SHALL drive the address (and mem_write_data<=rt for writes), assert the matching valid, go WAITING.
REQ-021 In WAITING, valid SHALL stay high and address/data stable until ready is sampled high.
REQ-022 On read ready: lsu_out<=mem_read_data, valid<=0, go DONE; on write ready: valid<=0, go DONE, lsu_out unchanged.
REQ-023 With ready permanently high, DONE SHALL be reached 3 cycles after the REQUEST-cycle edge; valid SHALL be high exactly 1 cycle.
REQ-024 Ready while valid is low SHALL be ignored.
REQ-025 DONE SHALL hold until core_state==UPDATE, then go IDLE and clear lsu_error; lsu_out SHALL persist.
REQ-026 enable low in any state SHALL stall: state, valids, addresses and lsu_out held; operation resumes on re-assertion.
REQ-027 Decode enables and rs/rt/decoded_offset SHALL be sampled only in REQUESTING; later changes have no effect.

Reset
REQ-028 On a rising clk edge with reset high, state SHALL be IDLE and lsu_out, lsu_error, both valids, both addresses and mem_write_data SHALL be 0.
REQ-029 Reset mid-access SHALL drop valid on that edge with no completion; a ready arriving the same cycle SHALL be ignored.
REQ-030 Reset SHALL take priority over enable and all other inputs.

Configuration
REQ-031 With LSU_TIMEOUT_EN defined, a counter SHALL count WAITING cycles; reaching TIMEOUT_CYCLES without ready SHALL drop valid, set lsu_error=1, go DONE, keep lsu_out.
REQ-032 The timeout counter SHALL clear on entering WAITING and SHALL not advance while enable is low.
REQ-033 Without LSU_TIMEOUT_EN, no counter SHALL exist, WAITING SHALL wait indefinitely and lsu_error SHALL be tied 0.

Verification
REQ-034 Read: rs=0x10, offset=0x02, ready=1, data=0x55, REQUEST -> read_address=0x12, valid 1 cycle, lsu_out=0x55, DONE at 3 cycles; UPDATE -> IDLE.
REQ-035 Write with 4-cycle ready delay: rs=0x20, offset=0xFF, rt=0xAA -> write_address=0x1F, write_data=0xAA held with valid for 4 cycles, then DONE, lsu_out unchanged.
REQ-036 Wrap/priority: rs=0xF0, offset=0x20, both enables high -> read only at address 0x10, mem_write_valid never asserted.
REQ-037 Stall/reset: enable low 3 cycles in WAITING -> all outputs frozen; reset asserted in WAITING -> IDLE, valid=0 next edge, lsu_out=0.
REQ-038 LSU_TIMEOUT_EN, ready=0 -> valid dropped after 16 WAITING cycles, lsu_error=1, DONE; UPDATE clears lsu_error; without macro, valid stays high 40+ cycles.

Source files
------------

// File: rtl/lsu_gen2.sv
// Load/store unit: one LDR/STR per core REQUEST phase, with a valid/ready memory handshake.
// Optional feature: define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without a ready.
module lsu_gen2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic [DATA_WIDTH-1:0] decoded_offset,
    input  logic                  mem_read_ready,
    input  logic                  mem_write_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_read_valid,
    output logic                  mem_write_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] lsu_out,
    output logic [1:0]            lsu_state,
    output logic                  lsu_error
);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {IDLE = 2'd0, REQUESTING = 2'd1, WAITING = 2'd2, DONE = 2'd3} state_t;

    state_t                state;
    logic                  is_write;
    logic [DATA_WIDTH-1:0] eff_sum;
    logic [ADDR_WIDTH-1:0] eff_addr;

    // Address arithmetic wraps at DATA_WIDTH, then is resized to the memory address width.
    assign eff_sum   = rs + decoded_offset;
    assign eff_addr  = ADDR_WIDTH'(eff_sum);
    assign lsu_state = state;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign lsu_error = err_q;
`else
    assign lsu_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            is_write          <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_write_valid   <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt          <= '0;
            err_q             <= 1'b0;
`endif
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable))
                        state <= REQUESTING;
                end
                REQUESTING: begin
`ifdef LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    // Read wins when both decode enables are set.
                    if (decoded_mem_read_enable) begin
                        mem_read_address <= eff_addr;
                        mem_read_valid   <= 1'b1;
                        is_write         <= 1'b0;
                        state            <= WAITING;
                    end else if (decoded_mem_write_enable) begin
                        mem_write_address <= eff_addr;
                        mem_write_data    <= rt;
                        mem_write_valid   <= 1'b1;
                        is_write          <= 1'b1;
                        state             <= WAITING;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAITING: begin
                    if (!is_write && mem_read_valid && mem_read_ready) begin
                        lsu_out        <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state          <= DONE;
                    end else if (is_write && mem_write_valid && mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        state           <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        err_q           <= 1'b1;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state <= IDLE;
`ifdef LSU_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_gen2.sv
// Scoreboard bench for lsu_gen2: expected requests/completions are queued at issue time
// and popped by a monitor when the DUT raises a valid or reaches DONE.
module tb_lsu_gen2;
    logic       clk = 1'b0;
    logic       reset, enable;
    logic [2:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, rt, decoded_offset;
    logic       mem_read_ready, mem_write_ready;
    logic [7:0] mem_read_data;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data, lsu_out;
    logic [1:0] lsu_state;
    logic       lsu_error;

    lsu_gen2 dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt), .decoded_offset(decoded_offset),
        .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
        .mem_read_data(mem_read_data),
        .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .lsu_out(lsu_out),
        .lsu_state(lsu_state), .lsu_error(lsu_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [7:0] a; logic [7:0] d; } req_t;
    typedef struct { logic [7:0] out; logic err; } done_t;
    req_t  req_q[$];
    done_t done_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on valid rising edges and on entry to DONE.
    logic       prev_rv = 1'b0, prev_wv = 1'b0;
    logic [1:0] prev_st = 2'd0;
    always @(negedge clk) begin
        req_t  r;
        done_t d;
        if (mem_read_valid === 1'b1 && !prev_rv) begin
            if (req_q.size() == 0) chk("unexpected_read", 1, 0);
            else begin
                r = req_q.pop_front();
                chk("mon_rd_kind", 0, {31'd0, r.w});
                chk("mon_rd_addr", mem_read_address, r.a);
            end
        end
        if (mem_write_valid === 1'b1 && !prev_wv) begin
            if (req_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                r = req_q.pop_front();
                chk("mon_wr_kind", 1, {31'd0, r.w});
                chk("mon_wr_addr", mem_write_address, r.a);
                chk("mon_wr_data", mem_write_data, r.d);
            end
        end
        if (lsu_state == 2'd3 && prev_st != 2'd3) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                d = done_q.pop_front();
                chk("mon_done_out", lsu_out, d.out);
                chk("mon_done_err", lsu_error, d.err);
            end
        end
        prev_rv = mem_read_valid;
        prev_wv = mem_write_valid;
        prev_st = lsu_state;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one REQUEST cycle then scrambles operands after REQUESTING to show they are not re-sampled.
    task automatic issue(input logic rd, input logic wr, input logic [7:0] b,
                         input logic [7:0] off, input logic [7:0] d);
        core_state = 3'b011; rd_en = rd; wr_en = wr; rs = b; decoded_offset = off; rt = d;
        tick();
        core_state = 3'b000;
        chk("st_requesting", lsu_state, 1);
        tick();
        rs = 8'hEE; decoded_offset = 8'h33; rt = 8'h99; rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic update();
        core_state = 3'b110;
        tick();
        core_state = 3'b000;
        chk("st_idle_after_update", lsu_state, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
        rs = 8'h00; rt = 8'h00; decoded_offset = 8'h00;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'h00;
        tick(); tick();
        chk("rst_state", lsu_state, 0);
        chk("rst_rv", mem_read_valid, 0);
        chk("rst_wv", mem_write_valid, 0);
        chk("rst_out", lsu_out, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_err", lsu_error, 0);
        reset = 1'b0;
        tick();

        // Read, ready always high: valid exactly one cycle, DONE two edges after REQUESTING.
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'h55;
        req_q.push_back('{1'b0, 8'h12, 8'h00});
        done_q.push_back('{8'h55, 1'b0});
        issue(1'b1, 1'b0, 8'h10, 8'h02, 8'h00);
        chk("rd_st_wait", lsu_state, 2);
        chk("rd_valid_hi", mem_read_valid, 1);
        chk("rd_addr", mem_read_address, 8'h12);
        tick();
        chk("rd_st_done", lsu_state, 3);
        chk("rd_valid_lo", mem_read_valid, 0);
        chk("rd_out", lsu_out, 8'h55);
        tick();
        chk("rd_hold_done", lsu_state, 3);
        update();
        chk("rd_out_persist", lsu_out, 8'h55);

        // Write with ready arriving after 4 valid cycles; offset 0xFF wraps to 0x1F.
        mem_write_ready = 1'b0; mem_read_data = 8'h66;
        req_q.push_back('{1'b1, 8'h1F, 8'hAA});
        done_q.push_back('{8'h55, 1'b0});
        issue(1'b0, 1'b1, 8'h20, 8'hFF, 8'hAA);
        for (int k = 0; k < 4; k++) begin
            chk("wr_valid_hi", mem_write_valid, 1);
            chk("wr_addr", mem_write_address, 8'h1F);
            chk("wr_data", mem_write_data, 8'hAA);
            chk("wr_st_wait", lsu_state, 2);
            if (k == 3) mem_write_ready = 1'b1;
            tick();
        end
        chk("wr_valid_lo", mem_write_valid, 0);
        chk("wr_st_done", lsu_state, 3);
        chk("wr_out_kept", lsu_out, 8'h55);
        update();

        // Both enables, address wrap: read only at 0x10.
        mem_read_data = 8'h3C;
        req_q.push_back('{1'b0, 8'h10, 8'h00});
        done_q.push_back('{8'h3C, 1'b0});
        issue(1'b1, 1'b1, 8'hF0, 8'h20, 8'h77);
        chk("pri_wv_lo", mem_write_valid, 0);
        chk("pri_raddr", mem_read_address, 8'h10);
        tick();
        chk("pri_wv_lo2", mem_write_valid, 0);
        chk("pri_out", lsu_out, 8'h3C);
        update();

        // Stall in WAITING (ready offered while disabled must be ignored), then reset mid-access.
        mem_read_ready = 1'b0; mem_read_data = 8'h81;
        req_q.push_back('{1'b0, 8'h06, 8'h00});
        issue(1'b1, 1'b0, 8'h05, 8'h01, 8'h00);
        enable = 1'b0; mem_read_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_state", lsu_state, 2);
            chk("stall_valid", mem_read_valid, 1);
            chk("stall_addr", mem_read_address, 8'h06);
            chk("stall_out", lsu_out, 8'h3C);
        end
        enable = 1'b1; mem_read_ready = 1'b0;
        tick();
        chk("resume_wait", lsu_state, 2);
        reset = 1'b1; mem_read_ready = 1'b1;
        tick();
        chk("rst_mid_state", lsu_state, 0);
        chk("rst_mid_valid", mem_read_valid, 0);
        chk("rst_mid_out", lsu_out, 0);
        chk("rst_mid_addr", mem_read_address, 0);
        reset = 1'b0; mem_read_ready = 1'b0;
        tick();
        chk("rst_mid_stay_idle", lsu_state, 0);

        // Ready never comes; a 2-cycle stall in the middle must not advance the wait count.
        mem_read_data = 8'h77;
        req_q.push_back('{1'b0, 8'h44, 8'h00});
`ifdef LSU_TIMEOUT_EN
        done_q.push_back('{8'h00, 1'b1});
        issue(1'b1, 1'b0, 8'h40, 8'h04, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        enable = 1'b0; tick(); tick(); enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("to_valid_hold", mem_read_valid, 1);
        end
        tick();
        chk("to_valid_lo", mem_read_valid, 0);
        chk("to_state_done", lsu_state, 3);
        chk("to_err", lsu_error, 1);
        chk("to_out_kept", lsu_out, 0);
        update();
        chk("to_err_clr", lsu_error, 0);
`else
        done_q.push_back('{8'h77, 1'b0});
        issue(1'b1, 1'b0, 8'h40, 8'h04, 8'h00);
        for (int k = 0; k < 45; k++) begin
            if (k == 10) enable = 1'b0;
            if (k == 12) enable = 1'b1;
            tick();
            if (k % 5 == 0) chk("nto_valid_hold", mem_read_valid, 1);
        end
        chk("nto_err", lsu_error, 0);
        mem_read_ready = 1'b1;
        tick();
        chk("nto_done", lsu_state, 3);
        chk("nto_out", lsu_out, 8'h77);
        update();
`endif

        tick();
        chk("sb_req_empty", req_q.size(), 0);
        chk("sb_done_empty", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
